// File: rtl/data_mem_unit.sv
// data_mem_unit: load/store responder for the decode-stage memory controls.
// It accepts one request at a time (LW, LH, LHU, SW) and answers after LATENCY
// cycles with extended load data and an alignment flag. The RAM is word
// organised, big-endian within a word, and the address wraps modulo its size.
module data_mem_unit #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic        loadFullWord,
  input  logic        loadSigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        misaligned
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  state_t              nextState_s;
  logic [3:0]          count_r;
  logic [3:0]          nextCount_s;
  logic                accept_s;
  logic                enterResp_s;

  // Latched request; only the address bits that reach the RAM are kept.
  logic [AW-1:0]       addr_r;
  logic [31:0]         wdata_r;
  logic                isStore_r;
  logic                fullWord_r;
  logic                signed_r;

  // Request view used when entering RESP: live inputs in IDLE (LATENCY=1), latched copy otherwise.
  logic [AW-1:0]       selAddr_s;
  logic                selStore_s;
  logic                selFull_s;
  logic                selSigned_s;

  logic [DEPTH_LOG2-1:0] wordIdx_s;
  logic [31:0]         ramWord_s;
  logic [15:0]         half_s;
  logic                misalign_s;
  logic [31:0]         loadData_s;

  logic                reqReady_r;
  logic                respValid_r;
  logic [31:0]         rdata_r;
  logic                misaligned_r;

  logic [31:0]         ram [0:(1<<DEPTH_LOG2)-1];

  // Address bits above the RAM size are deliberately dropped (wrap-around).
  logic                unusedAddrBits_s;
  assign unusedAddrBits_s = ^addr[31:AW];

  function automatic logic [31:0] extendHalf(input logic [15:0] half, input logic signExt);
    if (signExt) begin
      extendHalf = {{16{half[15]}}, half};
    end else begin
      extendHalf = {16'h0000, half};
    end
  endfunction

  // Next-state and latency-count logic of the IDLE/BUSY/RESP sequencer.
  always_comb begin
    nextState_s = state_r;
    nextCount_s = count_r;
    accept_s    = 1'b0;
    enterResp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid && (memRead || memWrite)) begin
          accept_s = 1'b1;
          if (LATENCY <= 1) begin
            nextState_s = RESP;
            nextCount_s = 4'd0;
            enterResp_s = 1'b1;
          end else begin
            nextState_s = BUSY;
            nextCount_s = 4'(LATENCY - 1);
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      BUSY: begin
        if (count_r <= 4'd1) begin
          nextState_s = RESP;
          nextCount_s = 4'd0;
          enterResp_s = 1'b1;
        end else begin
          nextCount_s = count_r - 4'd1;
        end
      end
      RESP: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s = IDLE;
        nextCount_s = 4'd0;
      end
    endcase
  end

  // Choose between live inputs and the latched request.
  always_comb begin
    if (state_r == IDLE) begin
      selAddr_s   = addr[AW-1:0];
      selStore_s  = memWrite;
      selFull_s   = loadFullWord;
      selSigned_s = loadSigned;
    end else begin
      selAddr_s   = addr_r;
      selStore_s  = isStore_r;
      selFull_s   = fullWord_r;
      selSigned_s = signed_r;
    end
  end

  // Alignment check and load-data formatting for the response.
  always_comb begin
    wordIdx_s = selAddr_s[AW-1:2];
    ramWord_s = ram[wordIdx_s];
    if (selAddr_s[1]) begin
      half_s = ramWord_s[15:0];
    end else begin
      half_s = ramWord_s[31:16];
    end
    if (selStore_s || selFull_s) begin
      misalign_s = (selAddr_s[1:0] != 2'b00);
    end else begin
      misalign_s = selAddr_s[0];
    end
    if (selStore_s || misalign_s) begin
      loadData_s = 32'h0000_0000;
    end else if (selFull_s) begin
      loadData_s = ramWord_s;
    end else begin
      loadData_s = extendHalf(half_s, selSigned_s);
    end
  end

  // Sequencer state and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      count_r <= 4'd0;
    end else begin
      state_r <= nextState_s;
      count_r <= nextCount_s;
    end
  end

  // Capture the request on accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r     <= '0;
      wdata_r    <= 32'h0000_0000;
      isStore_r  <= 1'b0;
      fullWord_r <= 1'b0;
      signed_r   <= 1'b0;
    end else if (accept_s) begin
      addr_r     <= addr[AW-1:0];
      wdata_r    <= wdata;
      isStore_r  <= memWrite;
      fullWord_r <= loadFullWord;
      signed_r   <= loadSigned;
    end
  end

  // Registered outputs; rdata/misaligned hold until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqReady_r   <= 1'b1;
      respValid_r  <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      misaligned_r <= 1'b0;
    end else begin
      reqReady_r  <= (nextState_s == IDLE);
      respValid_r <= enterResp_s;
      if (enterResp_s) begin
        rdata_r      <= loadData_s;
        misaligned_r <= misalign_s;
      end
    end
  end

  // Commit an aligned store at the end of its RESP cycle; a reset before then drops it.
  always_ff @(posedge clk) begin
    if (state_r == RESP && isStore_r && !misaligned_r) begin
      ram[addr_r[AW-1:2]] <= wdata_r;
    end
  end

  assign req_ready  = reqReady_r;
  assign resp_valid = respValid_r;
  assign rdata      = rdata_r;
  assign misaligned = misaligned_r;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: a word-array memory model predicts every cycle's
// outputs (ready, response pulse, held rdata/misaligned); directed accesses
// pin the model with literal results, then randomized traffic follows.
module tb_data_mem_unit;

  localparam int DL   = 8;
  localparam int L    = 2;
  localparam int NCYC = 4096;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, memRead, memWrite, loadFullWord, loadSigned;
  logic [31:0] addr, wdata, rdata;
  logic        resp_valid, misaligned;

  data_mem_unit #(.DEPTH_LOG2(DL), .LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .memRead(memRead), .memWrite(memWrite), .loadFullWord(loadFullWord),
    .loadSigned(loadSigned), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Model: memory contents plus expected outputs per cycle index.
  logic [31:0] mem [256];
  bit          expReady [NCYC];
  bit          expValid [NCYC];
  logic [31:0] expRdata [NCYC];
  bit          expMis   [NCYC];
  int          readyFrom = 0;
  int          lastResp  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void fillReset(int from);
    for (int c = from; c < NCYC; c++) begin
      expReady[c] = 1'b1;
      expValid[c] = 1'b0;
      expRdata[c] = 32'h0;
      expMis[c]   = 1'b0;
    end
  endfunction

  // Request sampled at edge k: busy for L cycles, pulse in the last one.
  function automatic void modelAccept(int k, bit rd, bit wr, bit full, bit sgn,
                                      logic [31:0] a, logic [31:0] d);
    int          idx;
    bit          mis;
    logic [31:0] r;
    logic [15:0] h;
    idx = int'(a[DL+1:2]);
    r   = 32'h0;
    if (wr) begin
      mis = (a[1:0] != 2'b00);
      if (!mis) mem[idx] = d;
    end else begin
      mis = full ? (a[1:0] != 2'b00) : a[0];
      if (!mis) begin
        h = a[1] ? mem[idx][15:0] : mem[idx][31:16];
        if (full)     r = mem[idx];
        else if (sgn) r = {{16{h[15]}}, h};
        else          r = {16'h0, h};
      end
    end
    for (int c = k; c < k + L && c < NCYC; c++) expReady[c] = 1'b0;
    if (k + L - 1 < NCYC) expValid[k + L - 1] = 1'b1;
    for (int c = k + L - 1; c < NCYC; c++) begin
      expRdata[c] = r;
      expMis[c]   = mis;
    end
    readyFrom = k + L + 1;
    lastResp  = k + L - 1;
  endfunction

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cyc < NCYC) begin
      chk("req_ready",  req_ready,  expReady[cyc]);
      chk("resp_valid", resp_valid, expValid[cyc]);
      chk("rdata",      rdata,      expRdata[cyc]);
      chk("misaligned", misaligned, expMis[cyc]);
    end
  end

  task automatic doReq(bit rd, bit wr, bit full, bit sgn, logic [31:0] a, logic [31:0] d);
    int g;
    g = 0;
    @(posedge clk); #2;
    while (cyc + 1 < readyFrom && g < 100) begin
      @(posedge clk); #2;
      g++;
    end
    if (g >= 100) chk("ready wait", 32'd0, 32'd1);
    req_valid = 1'b1; memRead = rd; memWrite = wr;
    loadFullWord = full; loadSigned = sgn; addr = a; wdata = d;
    modelAccept(cyc + 1, rd, wr, full, sgn, a, d);
    @(posedge clk); #2;
    req_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
  endtask

  task automatic expectResp(string name, logic [31:0] expR, bit expM);
    int g;
    g = 0;
    while (cyc < lastResp && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 50) chk({name, " timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({name, " valid"}, resp_valid, 32'd1);
    chk({name, " data"},  rdata,      expR);
    chk({name, " mis"},   misaligned, {31'd0, expM});
  endtask

  initial begin
    logic [31:0] a, d;
    bit rd, wr, full, sgn;
    rst_n = 1'b0; req_valid = 1'b0; memRead = 1'b0; memWrite = 1'b0;
    loadFullWord = 1'b0; loadSigned = 1'b0; addr = 32'h0; wdata = 32'h0;
    fillReset(0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    readyFrom = cyc + 1;
    chk("reset ready", req_ready, 32'd1);
    chk("reset rdata", rdata, 32'd0);
    chk("reset mis",   misaligned, 32'd0);

    // Give every word a known value.
    for (int i = 0; i < 256; i++) doReq(1'b0, 1'b1, 1'b1, 1'b0, i * 4, $urandom);

    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    expectResp("sw 0x10", 32'h0, 1'b0);
    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h14, 32'h01234567);
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    expectResp("lw 0x10", 32'hDEADBEEF, 1'b0);
    doReq(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 32'h0);
    expectResp("lh 0x10", 32'hFFFFDEAD, 1'b0);
    doReq(1'b1, 1'b0, 1'b0, 1'b0, 32'h12, 32'h0);
    expectResp("lhu 0x12", 32'h0000BEEF, 1'b0);
    doReq(1'b1, 1'b0, 1'b0, 1'b1, 32'h12, 32'h0);
    expectResp("lh 0x12", 32'hFFFFBEEF, 1'b0);
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0);
    expectResp("lw 0x13", 32'h0, 1'b1);
    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h16, 32'hFFFFFFFF);
    expectResp("sw 0x16", 32'h0, 1'b1);
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h14, 32'h0);
    expectResp("lw 0x14", 32'h01234567, 1'b0);
    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h400, 32'h12345678);
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    expectResp("wrap lw 0x0", 32'h12345678, 1'b0);
    doReq(1'b1, 1'b1, 1'b1, 1'b0, 32'h18, 32'hAABBCCDD);
    expectResp("rd+wr 0x18", 32'h0, 1'b0);
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h18, 32'h0);
    expectResp("lw 0x18", 32'hAABBCCDD, 1'b0);

    // Valid without an operation must be ignored.
    @(posedge clk); #2;
    req_valid = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    req_valid = 1'b0;

    // Reset during BUSY of a store: store dropped, outputs back to reset values.
    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'hCAFEF00D);
    doReq(1'b0, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0BADF00D);
    rst_n = 1'b0;
    mem[8] = 32'hCAFEF00D;
    fillReset(cyc);
    @(negedge clk);
    chk("mid reset ready", req_ready, 32'd1);
    chk("mid reset valid", resp_valid, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    readyFrom = cyc + 1;
    doReq(1'b1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    expectResp("lw 0x20 after reset", 32'hCAFEF00D, 1'b0);

    // Randomized traffic; inputs keep changing while the unit is busy.
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      req_valid = ($urandom_range(0, 9) < 7);
      wr   = ($urandom_range(0, 9) < 4);
      rd   = wr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 8);
      full = $urandom_range(0, 1);
      sgn  = $urandom_range(0, 1);
      a    = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (wr || full) a[1:0] = 2'b00;
        else            a[0]   = 1'b0;
      end
      d = $urandom;
      memRead = rd; memWrite = wr; loadFullWord = full; loadSigned = sgn;
      addr = a; wdata = d;
      if (cyc + 1 >= readyFrom && req_valid && (rd || wr))
        modelAccept(cyc + 1, rd, wr, full, sgn, a, d);
    end
    @(posedge clk); #2;
    req_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
